// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: gathers serial complex samples into 8-sample frames for dit_fft_8.
// Define FFT_BITREV_EN to store samples in bit-reversed (DIT input) slot order.
module fft_frame_loader #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_first_i,
  input  logic [W-1:0] in_re_i,
  input  logic [W-1:0] in_im_i,
  output logic         frame_valid_o,
  input  logic         frame_ready_i,
  output logic [W-1:0] inr0_o,
  output logic [W-1:0] inr1_o,
  output logic [W-1:0] inr2_o,
  output logic [W-1:0] inr3_o,
  output logic [W-1:0] inr4_o,
  output logic [W-1:0] inr5_o,
  output logic [W-1:0] inr6_o,
  output logic [W-1:0] inr7_o,
  output logic [W-1:0] ini0_o,
  output logic [W-1:0] ini1_o,
  output logic [W-1:0] ini2_o,
  output logic [W-1:0] ini3_o,
  output logic [W-1:0] ini4_o,
  output logic [W-1:0] ini5_o,
  output logic [W-1:0] ini6_o,
  output logic [W-1:0] ini7_o,
  output logic         err_resync_o,
  output logic [7:0]   frame_cnt_o
);

  logic [1:0]   full_q, full_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [2:0]   wr_cnt_q, wr_cnt_d;
  logic         err_q, err_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic [W-1:0] re_q [2][8];
  logic [W-1:0] re_d [2][8];
  logic [W-1:0] im_q [2][8];
  logic [W-1:0] im_d [2][8];

  logic         in_ready;
  logic         accept;
  logic         handoff;
  logic         resync;
  logic [2:0]   wr_idx;
  logic [2:0]   wr_slot;

  function automatic logic [2:0] slot_map(input logic [2:0] k);
`ifdef FFT_BITREV_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  assign in_ready = rst_i & ~full_q[wr_bank_q];
  assign accept   = in_valid_i & in_ready;
  assign handoff  = full_q[rd_bank_q] & frame_ready_i;
  // A start marker mid-frame restarts the frame at index 0.
  assign resync   = accept & in_first_i & (wr_cnt_q != 3'd0);
  assign wr_idx   = resync ? 3'd0 : wr_cnt_q;
  assign wr_slot  = slot_map(wr_idx);

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    re_d        = re_q;
    im_d        = im_q;

    if (accept) begin
      re_d[wr_bank_q][wr_slot] = in_re_i;
      im_d[wr_bank_q][wr_slot] = in_im_i;
      if (resync) begin
        wr_cnt_d = 3'd1;
        err_d    = 1'b1;
      end else if (wr_cnt_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = 3'd0;
      end else begin
        wr_cnt_d = wr_cnt_q + 3'd1;
      end
    end

    // Fill and handoff always address opposite banks, so both flag updates can coexist.
    if (handoff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= 3'd0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 8; s++) begin
          re_q[b][s] <= '0;
          im_q[b][s] <= '0;
        end
      end
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  assign in_ready_o    = in_ready;
  assign frame_valid_o = full_q[rd_bank_q];
  assign err_resync_o  = err_q;
  assign frame_cnt_o   = frame_cnt_q;

  assign inr0_o = re_q[rd_bank_q][0];
  assign inr1_o = re_q[rd_bank_q][1];
  assign inr2_o = re_q[rd_bank_q][2];
  assign inr3_o = re_q[rd_bank_q][3];
  assign inr4_o = re_q[rd_bank_q][4];
  assign inr5_o = re_q[rd_bank_q][5];
  assign inr6_o = re_q[rd_bank_q][6];
  assign inr7_o = re_q[rd_bank_q][7];
  assign ini0_o = im_q[rd_bank_q][0];
  assign ini1_o = im_q[rd_bank_q][1];
  assign ini2_o = im_q[rd_bank_q][2];
  assign ini3_o = im_q[rd_bank_q][3];
  assign ini4_o = im_q[rd_bank_q][4];
  assign ini5_o = im_q[rd_bank_q][5];
  assign ini6_o = im_q[rd_bank_q][6];
  assign ini7_o = im_q[rd_bank_q][7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed vector table, corner-case sequences, and a
// randomized run against a frame-queue reference model.
module tb_fft_frame_loader;

  localparam int W  = 9;
  localparam int CW = 16 * W;

  typedef struct packed {
    logic [7:0][W-1:0] re;
    logic [7:0][W-1:0] im;
  } frame_t;

  typedef struct {
    logic         rst;
    logic         vld;
    logic         first;
    logic         frdy;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         e_rdy;
    logic         e_fv;
    logic         e_err;
    logic [7:0]   e_cnt;
    logic         chk_dat;
    frame_t       e_dat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_r = 1'b0;
  logic         vld_r = 1'b0;
  logic         first_r = 1'b0;
  logic         frdy_r = 1'b0;
  logic [W-1:0] re_r = '0;
  logic [W-1:0] im_r = '0;

  logic         in_ready, frame_valid, err_resync;
  logic [7:0]   frame_cnt;
  logic [W-1:0] o_re [8];
  logic [W-1:0] o_im [8];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_model = 1'b0;

  // Reference model: pending frames in natural sample order, plus the partial frame.
  frame_t     mq[$];
  frame_t     m_cur;
  int         m_cnt;
  logic       m_err;
  logic [7:0] m_fcnt;

  always #5 clk = ~clk;

  fft_frame_loader #(.W(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_r),
    .in_valid_i    (vld_r),
    .in_ready_o    (in_ready),
    .in_first_i    (first_r),
    .in_re_i       (re_r),
    .in_im_i       (im_r),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frdy_r),
    .inr0_o        (o_re[0]),
    .inr1_o        (o_re[1]),
    .inr2_o        (o_re[2]),
    .inr3_o        (o_re[3]),
    .inr4_o        (o_re[4]),
    .inr5_o        (o_re[5]),
    .inr6_o        (o_re[6]),
    .inr7_o        (o_re[7]),
    .ini0_o        (o_im[0]),
    .ini1_o        (o_im[1]),
    .ini2_o        (o_im[2]),
    .ini3_o        (o_im[3]),
    .ini4_o        (o_im[4]),
    .ini5_o        (o_im[5]),
    .ini6_o        (o_im[6]),
    .ini7_o        (o_im[7]),
    .err_resync_o  (err_resync),
    .frame_cnt_o   (frame_cnt)
  );

  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // Output slot j carries the sample the configured ordering assigns to it.
  function automatic frame_t mk_out(input frame_t n);
    frame_t o;
    for (int j = 0; j < 8; j++) begin
`ifdef FFT_BITREV_EN
      o.re[j] = n.re[brev(j)];
      o.im[j] = n.im[brev(j)];
`else
      o.re[j] = n.re[j];
      o.im[j] = n.im[j];
`endif
    end
    return o;
  endfunction

  function automatic frame_t nat_seq(input int base, input int imoff);
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f.re[k] = W'(base + k);
      f.im[k] = W'(base + k + imoff);
    end
    return f;
  endfunction

  function automatic frame_t dut_frame();
    frame_t f;
    for (int j = 0; j < 8; j++) begin
      f.re[j] = o_re[j];
      f.im[j] = o_im[j];
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int sz;
    bit acc;
    bit ho;
    if (!rst_r) begin
      mq.delete();
      m_cnt  = 0;
      m_err  = 1'b0;
      m_fcnt = 8'd0;
    end else begin
      sz    = mq.size();
      acc   = vld_r && (sz < 2);
      ho    = frdy_r && (sz > 0);
      m_err = 1'b0;
      if (ho) begin
        void'(mq.pop_front());
        m_fcnt = m_fcnt + 8'd1;
      end
      if (acc) begin
        if (first_r && m_cnt != 0) begin
          m_cur.re[0] = re_r;
          m_cur.im[0] = im_r;
          m_cnt = 1;
          m_err = 1'b1;
        end else begin
          m_cur.re[m_cnt] = re_r;
          m_cur.im[m_cnt] = im_r;
          m_cnt++;
          if (m_cnt == 8) begin
            mq.push_back(m_cur);
            m_cnt = 0;
          end
        end
      end
    end
  endtask

  task automatic model_cmp();
    chk("m_ready", in_ready, rst_r && (mq.size() < 2));
    chk("m_fvalid", frame_valid, mq.size() > 0);
    chk("m_err", err_resync, m_err);
    chk("m_fcnt", frame_cnt, m_fcnt);
    if (mq.size() > 0) chk("m_data", dut_frame(), mk_out(mq[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_model) model_cmp();
  endtask

  task automatic drive(input logic v, input logic f, input int re, input int im);
    vld_r   = v;
    first_r = f;
    re_r    = W'(re);
    im_r    = W'(im);
  endtask

  task automatic do_reset();
    rst_r = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    step();
    rst_r = 1'b1;
  endtask

  vec_t tv[11];
  int   err_pulses;

  initial begin
    // Directed table: reset, then one natural frame re=k, im=-k with frame_ready=1.
    tv[0] = '{rst:1'b0, vld:1'b0, first:1'b0, frdy:1'b0, re:'0, im:'0,
              e_rdy:1'b0, e_fv:1'b0, e_err:1'b0, e_cnt:8'd0, chk_dat:1'b1, e_dat:'0};
    for (int k = 0; k < 8; k++) begin
      frame_t nf;
      for (int s = 0; s < 8; s++) begin
        nf.re[s] = W'(s);
        nf.im[s] = W'(0 - s);
      end
      tv[k+1] = '{rst:1'b1, vld:1'b1, first:(k == 0), frdy:1'b1, re:W'(k), im:W'(0 - k),
                  e_rdy:1'b1, e_fv:(k == 7), e_err:1'b0, e_cnt:8'd0, chk_dat:(k == 7),
                  e_dat:mk_out(nf)};
    end
    tv[9]  = '{rst:1'b1, vld:1'b0, first:1'b0, frdy:1'b1, re:'0, im:'0,
               e_rdy:1'b1, e_fv:1'b0, e_err:1'b0, e_cnt:8'd1, chk_dat:1'b0, e_dat:'0};
    tv[10] = '{rst:1'b1, vld:1'b0, first:1'b0, frdy:1'b0, re:'0, im:'0,
               e_rdy:1'b1, e_fv:1'b0, e_err:1'b0, e_cnt:8'd1, chk_dat:1'b0, e_dat:'0};

    for (int i = 0; i < 11; i++) begin
      rst_r   = tv[i].rst;
      vld_r   = tv[i].vld;
      first_r = tv[i].first;
      frdy_r  = tv[i].frdy;
      re_r    = tv[i].re;
      im_r    = tv[i].im;
      step();
      chk($sformatf("tv%0d_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_fvalid", i), frame_valid, tv[i].e_fv);
      chk($sformatf("tv%0d_err", i), err_resync, tv[i].e_err);
      chk($sformatf("tv%0d_fcnt", i), frame_cnt, tv[i].e_cnt);
      if (tv[i].chk_dat) chk($sformatf("tv%0d_data", i), dut_frame(), tv[i].e_dat);
    end

    // Backpressure: two frames buffered, 17th sample held until the first handoff.
    do_reset();
    frdy_r = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      drive(1'b1, (n == 1) || (n == 9), n, n + 50);
      step();
    end
    chk("bp_ready_full", in_ready, 1'b0);
    chk("bp_fvalid", frame_valid, 1'b1);
    drive(1'b1, 1'b1, 17, 67);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_ready", in_ready, 1'b0);
      chk("bp_hold_data", dut_frame(), mk_out(nat_seq(1, 50)));
      chk("bp_hold_fcnt", frame_cnt, 8'd0);
    end
    frdy_r = 1'b1;
    step();
    chk("bp_h1_fcnt", frame_cnt, 8'd1);
    chk("bp_h1_fvalid", frame_valid, 1'b1);
    chk("bp_h1_data", dut_frame(), mk_out(nat_seq(9, 50)));
    chk("bp_h1_ready", in_ready, 1'b1);
    step();
    chk("bp_h2_fcnt", frame_cnt, 8'd2);
    chk("bp_h2_fvalid", frame_valid, 1'b0);
    frdy_r = 1'b0;
    for (int n = 18; n <= 24; n++) begin
      drive(1'b1, 1'b0, n, n + 50);
      step();
    end
    drive(1'b0, 1'b0, 0, 0);
    chk("bp_s17_fvalid", frame_valid, 1'b1);
    chk("bp_s17_data", dut_frame(), mk_out(nat_seq(17, 50)));

    // Resync: 5 samples then a start marker with re=100.
    do_reset();
    frdy_r = 1'b1;
    err_pulses = 0;
    for (int n = 1; n <= 5; n++) begin
      drive(1'b1, n == 1, n, n);
      step();
      if (err_resync) err_pulses++;
    end
    chk("rs_pre_err", err_resync, 1'b0);
    drive(1'b1, 1'b1, 100, 100);
    step();
    chk("rs_err_pulse", err_resync, 1'b1);
    if (err_resync) err_pulses++;
    for (int n = 101; n <= 107; n++) begin
      drive(1'b1, 1'b0, n, n);
      step();
      if (err_resync) err_pulses++;
    end
    drive(1'b0, 1'b0, 0, 0);
    chk("rs_fvalid", frame_valid, 1'b1);
    chk("rs_data", dut_frame(), mk_out(nat_seq(100, 0)));
    step();
    if (err_resync) err_pulses++;
    chk("rs_fcnt", frame_cnt, 8'd1);
    chk("rs_pulses", err_pulses, 1);

    // Reset mid-frame with a held frame present.
    do_reset();
    frdy_r = 1'b0;
    for (int n = 0; n < 11; n++) begin
      drive(1'b1, n == 0 || n == 8, 200 + n, 300 + n);
      step();
    end
    chk("mr_pre_fvalid", frame_valid, 1'b1);
    rst_r = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("mr_fvalid", frame_valid, 1'b0);
    chk("mr_data_zero", dut_frame(), frame_t'(0));
    chk("mr_ready", in_ready, 1'b0);
    chk("mr_err", err_resync, 1'b0);
    chk("mr_fcnt", frame_cnt, 8'd0);
    rst_r  = 1'b1;
    frdy_r = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, n == 0, 30 + n, 35 + n);
      step();
    end
    drive(1'b0, 1'b0, 0, 0);
    chk("mr_new_fvalid", frame_valid, 1'b1);
    chk("mr_new_data", dut_frame(), mk_out(nat_seq(30, 5)));
    step();
    chk("mr_new_fcnt", frame_cnt, 8'd1);
    chk("mr_new_err", err_resync, 1'b0);

    // 256 back-to-back frames at full rate; frame counter wraps to 0.
    do_reset();
    chk_model = 1'b1;
    frdy_r = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      drive(1'b1, (i % 8) == 0, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
      step();
      chk("b2b_ready", in_ready, 1'b1);
    end
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("b2b_wrap_fcnt", frame_cnt, 8'd0);
    chk("b2b_fvalid", frame_valid, 1'b0);

    // Random gaps, backpressure, start markers and rare resets against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_r  = ($urandom_range(0, 299) != 0);
      frdy_r = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
      step();
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
